// File: rtl/cam_axi_burst_writer.sv
// cam_axi_burst_writer: drains a first-word-fall-through FIFO into one AXI4 INCR write burst per request.
// Optional macro CAM_AXI_BRESP_WAIT_EN: wait for the write response (RESP state) before signalling finish.
module cam_axi_burst_writer #(
    parameter int MEM_DATA_BITS = 64,
    parameter int ADDR_BITS     = 32,
    parameter int BURST_BITS    = 10
) (
    input  logic                       aclk,
    input  logic                       rst,
    input  logic                       wr_burst_req,
    input  logic [BURST_BITS-1:0]      wr_burst_len,
    input  logic [ADDR_BITS-1:0]       wr_burst_addr,
    output logic                       wr_burst_finish,
    input  logic [MEM_DATA_BITS-1:0]   fifo_dout,
    input  logic                       fifo_empty,
    output logic                       fifo_rd_en,
    output logic [ADDR_BITS-1:0]       awaddr,
    output logic [7:0]                 awlen,
    output logic [2:0]                 awsize,
    output logic [1:0]                 awburst,
    output logic                       awvalid,
    input  logic                       awready,
    output logic [MEM_DATA_BITS-1:0]   wdata,
    output logic [MEM_DATA_BITS/8-1:0] wstrb,
    output logic                       wlast,
    output logic                       wvalid,
    input  logic                       wready,
    input  logic                       bvalid,
    input  logic [1:0]                 bresp,
    output logic                       bready,
    output logic                       len_err
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADDR = 3'd1,
        DATA = 3'd2,
`ifdef CAM_AXI_BRESP_WAIT_EN
        RESP = 3'd3,
`endif
        DONE = 3'd4
    } state_t;

    state_t               state, state_n;
    logic [ADDR_BITS-1:0] addr_q;
    logic [8:0]           len_q;
    logic [8:0]           len_m1;
    logic [8:0]           beat_cnt;
    logic [8:0]           req_len;
    logic                 len_over;
    logic                 beat_hs;

    // One AXI4 burst carries at most 256 beats; longer requests are clipped.
    function automatic logic [8:0] sat_len(input logic [BURST_BITS-1:0] len);
        logic [31:0] wide;
        wide = 32'(len);
        return (wide > 32'd256) ? 9'd256 : wide[8:0];
    endfunction

    assign req_len  = sat_len(wr_burst_len);
    assign len_over = (32'(wr_burst_len) > 32'd256);
    assign len_m1   = len_q - 9'd1;

    assign awaddr  = addr_q;
    assign awlen   = len_m1[7:0];
    assign awsize  = 3'd3;
    assign awburst = 2'b01;
    assign wstrb   = '1;
    assign wdata   = fifo_dout;

    assign awvalid         = (state == ADDR);
    assign wvalid          = (state == DATA) && !fifo_empty;
    assign wlast           = (state == DATA) && (beat_cnt == len_m1);
    assign beat_hs         = wvalid && wready;
    assign fifo_rd_en      = beat_hs && !rst;
    assign wr_burst_finish = (state == DONE);

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (wr_burst_req) begin
                    state_n = (req_len == 9'd0) ? DONE : ADDR;
                end
            end
            ADDR: begin
                if (awready) begin
                    state_n = DATA;
                end
            end
            DATA: begin
                if (beat_hs && wlast) begin
`ifdef CAM_AXI_BRESP_WAIT_EN
                    state_n = RESP;
`else
                    state_n = DONE;
`endif
                end
            end
`ifdef CAM_AXI_BRESP_WAIT_EN
            RESP: begin
                if (bvalid) begin
                    state_n = DONE;
                end
            end
`endif
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (rst) begin
            state    <= IDLE;
            addr_q   <= '0;
            len_q    <= '0;
            beat_cnt <= '0;
            len_err  <= 1'b0;
        end else begin
            state <= state_n;
            if (state == IDLE && wr_burst_req) begin
                addr_q <= wr_burst_addr;
                len_q  <= req_len;
                if (len_over || req_len == 9'd0) begin
                    len_err <= 1'b1;
                end
            end
            if (beat_hs) begin
                beat_cnt <= wlast ? 9'd0 : beat_cnt + 9'd1;
            end
        end
    end

    // The response status never changes sequencing; it is deliberately left unused.
`ifdef CAM_AXI_BRESP_WAIT_EN
    logic unused_resp;
    assign bready      = (state == RESP);
    assign unused_resp = ^bresp;
`else
    // Response accepted unconditionally; held low only while in reset.
    logic bready_q;
    logic unused_resp;
    always_ff @(posedge aclk) begin
        if (rst) begin
            bready_q <= 1'b0;
        end else begin
            bready_q <= 1'b1;
        end
    end
    assign bready      = bready_q;
    assign unused_resp = ^{bvalid, bresp};
`endif

endmodule

// File: tb/tb_cam_axi_burst_writer.sv
// Scoreboard bench for cam_axi_burst_writer: FIFO model, AXI slave driver and negedge monitor.
module tb_cam_axi_burst_writer;
    localparam int DW      = 64;
    localparam int AW      = 32;
    localparam int BW      = 10;
    localparam int B_DELAY = 10;

    logic          aclk = 1'b0;
    logic          rst;
    logic          wr_burst_req;
    logic [BW-1:0] wr_burst_len;
    logic [AW-1:0] wr_burst_addr;
    logic          wr_burst_finish;
    logic [DW-1:0] fifo_dout;
    logic          fifo_empty;
    logic          fifo_rd_en;
    logic [AW-1:0] awaddr;
    logic [7:0]    awlen;
    logic [2:0]    awsize;
    logic [1:0]    awburst;
    logic          awvalid;
    logic          awready;
    logic [DW-1:0] wdata;
    logic [DW/8-1:0] wstrb;
    logic          wlast;
    logic          wvalid;
    logic          wready;
    logic          bvalid;
    logic [1:0]    bresp;
    logic          bready;
    logic          len_err;

    always #5 aclk = ~aclk;

    cam_axi_burst_writer #(
        .MEM_DATA_BITS(DW), .ADDR_BITS(AW), .BURST_BITS(BW)
    ) dut (
        .aclk(aclk), .rst(rst),
        .wr_burst_req(wr_burst_req), .wr_burst_len(wr_burst_len),
        .wr_burst_addr(wr_burst_addr), .wr_burst_finish(wr_burst_finish),
        .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
        .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bresp(bresp), .bready(bready), .len_err(len_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // FWFT FIFO model
    logic [DW-1:0] fifo_mem [0:1023];
    int            wr_ptr = 0;
    int            rd_ptr = 0;
    logic          empty_gate;
    logic          fifo_flush = 1'b0;

    assign fifo_empty = (rd_ptr == wr_ptr) || empty_gate;
    assign fifo_dout  = fifo_mem[rd_ptr[9:0]];

    always @(posedge aclk) begin
        if (fifo_flush) rd_ptr <= wr_ptr;
        else if (fifo_rd_en) rd_ptr <= rd_ptr + 1;
    end

    logic [DW-1:0]   exp_q[$];
    logic [AW+7:0]   aw_q[$];
    logic [AW+7:0]   aw_head;

    task automatic load_fifo(input int n, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) begin
            fifo_mem[wr_ptr[9:0]] = base + DW'(i * 3 + 1);
            exp_q.push_back(base + DW'(i * 3 + 1));
            wr_ptr++;
        end
    endtask

    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    // Monitor: samples on the falling edge what the next rising edge will see
    int beat_idx = 0, cur_len = 0, exp_fin = -1;
    int beats_tot = 0, aw_cyc_tot = 0, aw_hs_tot = 0, fin_tot = 0, rd_tot = 0;
    int b_due_cyc = -100, b_hs_cyc = -100;
    bit aw_done = 1'b0;

    always @(negedge aclk) begin
        if (rst) begin
            check("rd_en_in_reset", fifo_rd_en, 1'b0);
            aw_done  = 1'b0;
            beat_idx = 0;
        end else begin
            if (awvalid || wvalid) check("aw_w_exclusive", awvalid && wvalid, 1'b0);
            if (wvalid || fifo_rd_en) check("rd_en", fifo_rd_en, wvalid && wready);
            if (awvalid) begin
                aw_cyc_tot++;
                if (aw_q.size() == 0) begin
                    check("aw_unexpected", 1'b1, 1'b0);
                end else begin
                    aw_head = aw_q[0];
                    check("awaddr", awaddr, aw_head[AW+7:8]);
                    check("awlen", awlen, aw_head[7:0]);
                    if (awready) begin
                        check("awsize", awsize, 3'd3);
                        check("awburst", awburst, 2'b01);
                        cur_len  = int'(aw_head[7:0]) + 1;
                        beat_idx = 0;
                        aw_done  = 1'b1;
                        aw_hs_tot++;
                        void'(aw_q.pop_front());
                    end
                end
            end
            if (wvalid) begin
                check("w_after_aw", aw_done, 1'b1);
                check("wlast", wlast, beat_idx == cur_len - 1);
                if (wready) begin
                    if (exp_q.size() == 0) check("w_unexpected", 1'b1, 1'b0);
                    else check("wdata", wdata, exp_q.pop_front());
                    check("wstrb", wstrb, {(DW/8){1'b1}});
                    beats_tot++;
                    beat_idx++;
                    if (wlast) begin
                        aw_done   = 1'b0;
                        b_due_cyc = cyc + 1 + B_DELAY;
`ifndef CAM_AXI_BRESP_WAIT_EN
                        exp_fin = cyc + 1;
`endif
                    end
                end
            end
            if (fifo_rd_en) rd_tot++;
            if (bvalid && bready) begin
                b_hs_cyc = cyc;
`ifdef CAM_AXI_BRESP_WAIT_EN
                exp_fin = cyc + 1;
`endif
            end
            if (wr_burst_finish) begin
                fin_tot++;
                check("finish_cycle", cyc, exp_fin);
            end
        end
    end

    // AXI slave / FIFO-gate driver, updated 1 time unit after each rising edge
    int aw_delay = 0, aw_hold = 0;
    bit wready_rand = 1'b0, empty_toggle = 1'b0;

    initial begin
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00; empty_gate = 1'b0;
        forever begin
            @(posedge aclk);
            #1;
            if (awvalid) begin
                awready = (aw_hold >= aw_delay);
                aw_hold++;
            end else begin
                aw_hold = 0;
                awready = (aw_delay == 0);
            end
            wready     = wready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            empty_gate = empty_toggle ? ~empty_gate : 1'b0;
            if (cyc == b_due_cyc) begin
                bvalid = 1'b1;
                bresp  = 2'b10;
            end else if (bvalid && b_hs_cyc == cyc - 1) begin
                bvalid = 1'b0;
            end
        end
    end

    int beats0, aw_cyc0, aw_hs0, rd0, fin0;

    task automatic run_burst(input int len, input logic [AW-1:0] addr, input int budget);
        int eff;
        int waited;
        eff     = (len > 256) ? 256 : len;
        beats0  = beats_tot; aw_cyc0 = aw_cyc_tot; aw_hs0 = aw_hs_tot;
        rd0     = rd_tot;    fin0    = fin_tot;
        if (eff != 0) aw_q.push_back({addr, 8'(eff - 1)});
        else exp_fin = cyc + 1;
        wr_burst_req  = 1'b1;
        wr_burst_len  = BW'(len);
        wr_burst_addr = addr;
        waited = 0;
        while (fin_tot == fin0 && waited < budget) begin
            @(posedge aclk);
            #1;
            waited++;
        end
        wr_burst_req = 1'b0;
        if (fin_tot == fin0) check("finish_timeout", 1'b0, 1'b1);
        repeat (3) @(posedge aclk);
        #1;
        check("finish_pulses", fin_tot - fin0, 1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_awvalid"}, awvalid, 1'b0);
        check({tag, "_wvalid"}, wvalid, 1'b0);
        check({tag, "_wlast"}, wlast, 1'b0);
        check({tag, "_finish"}, wr_burst_finish, 1'b0);
        check({tag, "_bready"}, bready, 1'b0);
        check({tag, "_len_err"}, len_err, 1'b0);
        check({tag, "_rd_en"}, fifo_rd_en, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, summary not printed");
        $fatal(1, "watchdog");
    end

    initial begin
        int waited;
        rst = 1'b1; wr_burst_req = 1'b0; wr_burst_len = '0; wr_burst_addr = '0;
        repeat (3) @(posedge aclk);
        #1;
        check_idle_outputs("reset");
        rst = 1'b0;
        @(posedge aclk);
        #1;

        // Len 16, full FIFO, always ready
        load_fifo(16, 64'hA5A5_0000_0000_1000);
        run_burst(16, 32'h0000_1000, 200);
        check("t1_beats", beats_tot - beats0, 16);
        check("t1_aw_hs", aw_hs_tot - aw_hs0, 1);
        check("t1_rd_en_cnt", rd_tot - rd0, 16);
        check("t1_len_err", len_err, 1'b0);
        check("t1_sb_drained", exp_q.size(), 0);

        // Len 8, awready held off for 5 awvalid cycles
        aw_delay = 5;
        load_fifo(8, 64'h0BAD_CAFE_0000_2000);
        run_burst(8, 32'h0000_2000, 200);
        aw_delay = 0;
        check("t2_aw_cycles", aw_cyc_tot - aw_cyc0, 6);
        check("t2_beats", beats_tot - beats0, 8);

        // Len 4, FIFO empty every other cycle, random wready
        empty_toggle = 1'b1; wready_rand = 1'b1;
        load_fifo(4, 64'h1234_5678_0000_3000);
        run_burst(4, 32'h0000_3000, 300);
        empty_toggle = 1'b0; wready_rand = 1'b0;
        check("t3_beats", beats_tot - beats0, 4);
        check("t3_rd_en_cnt", rd_tot - rd0, 4);

        // Len 300 saturates to 256 and flags len_err
        load_fifo(256, 64'h7700_0000_0000_4000);
        run_burst(300, 32'h0000_4000, 1000);
        check("t4_beats", beats_tot - beats0, 256);
        check("t4_len_err", len_err, 1'b1);
        check("t4_sb_drained", exp_q.size(), 0);

        // Reset clears the sticky flag; len 0 sets it and finishes with no AXI traffic
        rst = 1'b1;
        @(posedge aclk);
        #1;
        check("t5_len_err_cleared", len_err, 1'b0);
        rst = 1'b0;
        @(posedge aclk);
        #1;
        run_burst(0, 32'h0000_5000, 20);
        check("t5_no_awvalid", aw_cyc_tot - aw_cyc0, 0);
        check("t5_no_beats", beats_tot - beats0, 0);
        check("t5_len_err", len_err, 1'b1);

        // Reset after beat 3 of 16, then a clean burst
        load_fifo(16, 64'hDEAD_0000_0000_6000);
        beats0 = beats_tot;
        aw_q.push_back({32'h0000_6000, 8'd15});
        wr_burst_req = 1'b1; wr_burst_len = BW'(16); wr_burst_addr = 32'h0000_6000;
        waited = 0;
        while (beats_tot - beats0 < 3 && waited < 100) begin
            @(posedge aclk);
            #1;
            waited++;
        end
        check("t6_reached_beat3", beats_tot - beats0, 3);
        rst = 1'b1; wr_burst_req = 1'b0; fifo_flush = 1'b1;
        @(posedge aclk);
        #1;
        check_idle_outputs("t6_reset");
        rst = 1'b0; fifo_flush = 1'b0;
        exp_q.delete();
        aw_q.delete();
        @(posedge aclk);
        #1;
        load_fifo(16, 64'hC0DE_0000_0000_7000);
        run_burst(16, 32'h0000_7000, 200);
        check("t6_clean_beats", beats_tot - beats0, 16);
        check("t6_clean_rd_en_cnt", rd_tot - rd0, 16);
        check("t6_sb_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
